// File: rtl/reg_select_decoder.sv
// Register-select decoder: latches the instruction word, decodes Ra/Rb/Rc into
// registered one-hot register-in/out strobes, and scans all registers onto the bus.
module reg_select_decoder #(
  parameter int REG_COUNT = 16
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        ir_load,
  input  logic [31:0] ir_in,
  input  logic        gra,
  input  logic        grb,
  input  logic        grc,
  input  logic        r_in_en,
  input  logic        r_out_en,
  input  logic        ba_out,
  input  logic        scan_start,
  input  logic        scan_ready,
  output logic [31:0] r_in_sel,
  output logic [31:0] r_out_sel,
  output logic [4:0]  sel_index,
  output logic        scan_busy,
  output logic        scan_valid,
  output logic        scan_done
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  localparam logic [3:0] LAST_IDX = 4'(REG_COUNT - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_ir;
  logic [3:0]  r_idx;
  logic [3:0]  w_idx_nxt;
  logic [3:0]  w_field_raw;
  logic [4:0]  w_field;
  logic        w_field_ok;
  logic [31:0] w_field_hot;
  logic [31:0] w_in_nxt;
  logic [31:0] w_out_nxt;
  logic [4:0]  w_sel_nxt;
  logic        w_done_nxt;
  logic        w_unused_ir;

  // Only the three register fields of the IR feed the decoder.
  assign w_unused_ir = ^{r_ir[31:27], r_ir[14:0]};

  always_comb begin
    w_field_raw = 4'd0;
    if (gra)      w_field_raw = r_ir[26:23];
    else if (grb) w_field_raw = r_ir[22:19];
    else if (grc) w_field_raw = r_ir[18:15];
  end

  assign w_field     = {1'b0, w_field_raw};
  assign w_field_ok  = (int'(w_field) < REG_COUNT);
  assign w_field_hot = w_field_ok ? (32'd1 << w_field) : 32'd0;

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_in_nxt    = 32'd0;
    w_out_nxt   = 32'd0;
    w_sel_nxt   = 5'd0;
    w_done_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        w_idx_nxt = 4'd0;
        if (scan_start) begin
          w_state_nxt = SCAN;
          w_out_nxt   = 32'd1;
        end else begin
          w_in_nxt  = r_in_en ? w_field_hot : 32'd0;
          w_out_nxt = (r_out_en || (ba_out && (w_field != 5'd0))) ? w_field_hot : 32'd0;
          w_sel_nxt = w_field;
        end
      end
      SCAN: begin
        if (scan_ready && (r_idx == LAST_IDX)) begin
          w_state_nxt = DONE;
          w_done_nxt  = 1'b1;
        end else begin
          // A stalled handshake re-registers the same index, so outputs hold.
          if (scan_ready) w_idx_nxt = r_idx + 4'd1;
          w_out_nxt = 32'd1 << w_idx_nxt;
          w_sel_nxt = {1'b0, w_idx_nxt};
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
        w_idx_nxt   = 4'd0;
      end
      default: begin
        w_state_nxt = IDLE;
        w_idx_nxt   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_state   <= IDLE;
      r_idx     <= 4'd0;
      r_in_sel  <= 32'd0;
      r_out_sel <= 32'd0;
      sel_index <= 5'd0;
      scan_done <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_idx     <= w_idx_nxt;
      r_in_sel  <= w_in_nxt;
      r_out_sel <= w_out_nxt;
      sel_index <= w_sel_nxt;
      scan_done <= w_done_nxt;
    end
  end

  // The IR is frozen while a scan owns the outputs.
  always_ff @(posedge clock or posedge clear) begin
    if (clear)                           r_ir <= 32'd0;
    else if (ir_load && r_state == IDLE) r_ir <= ir_in;
  end

  assign scan_busy  = (r_state != IDLE);
  assign scan_valid = (r_state == SCAN);

endmodule

// File: tb/tb_reg_select_decoder.sv
// Directed-vector bench for reg_select_decoder with hand-computed expectations.
module tb_reg_select_decoder;

  logic        clock = 1'b0;
  logic        clear = 1'b1;
  logic        ir_load = 1'b0;
  logic [31:0] ir_in = 32'd0;
  logic        gra = 1'b0, grb = 1'b0, grc = 1'b0;
  logic        r_in_en = 1'b0, r_out_en = 1'b0, ba_out = 1'b0;
  logic        scan_start = 1'b0, scan_ready = 1'b0;
  logic [31:0] r_in_sel, r_out_sel;
  logic [4:0]  sel_index;
  logic        scan_busy, scan_valid, scan_done;

  int n_cmp = 0;
  int n_err = 0;

  reg_select_decoder #(.REG_COUNT(16)) dut (
    .clock(clock), .clear(clear), .ir_load(ir_load), .ir_in(ir_in),
    .gra(gra), .grb(grb), .grc(grc),
    .r_in_en(r_in_en), .r_out_en(r_out_en), .ba_out(ba_out),
    .scan_start(scan_start), .scan_ready(scan_ready),
    .r_in_sel(r_in_sel), .r_out_sel(r_out_sel), .sel_index(sel_index),
    .scan_busy(scan_busy), .scan_valid(scan_valid), .scan_done(scan_done)
  );

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic ctl(input logic a, input logic b, input logic c,
                     input logic ie, input logic oe, input logic ba);
    gra = a; grb = b; grc = c; r_in_en = ie; r_out_en = oe; ba_out = ba;
  endtask

  initial begin
    #3;
    check_val("rst_in_sel",  r_in_sel, 32'd0);
    check_val("rst_out_sel", r_out_sel, 32'd0);
    check_val("rst_sel_idx", 32'(sel_index), 32'd0);
    check_val("rst_busy",    32'(scan_busy), 32'd0);
    check_val("rst_valid",   32'(scan_valid), 32'd0);
    check_val("rst_done",    32'(scan_done), 32'd0);
    @(negedge clock);
    clear = 1'b0;

    // Field decode: Ra=5, Rb=2, Rc=7
    ir_in = 32'h02938000; ir_load = 1'b1;
    tick();
    ir_load = 1'b0;
    ctl(1, 0, 0, 1, 0, 0); tick();
    check_val("ra_in_sel", r_in_sel, 32'h20);
    check_val("ra_sel_idx", 32'(sel_index), 32'd5);
    check_val("ra_out_sel", r_out_sel, 32'd0);
    ctl(0, 1, 0, 0, 1, 0); tick();
    check_val("rb_out_sel", r_out_sel, 32'h4);
    check_val("rb_in_sel", r_in_sel, 32'd0);
    ctl(0, 0, 1, 0, 1, 0); tick();
    check_val("rc_out_sel", r_out_sel, 32'h80);
    check_val("rc_sel_idx", 32'(sel_index), 32'd7);

    // BAout and priority
    ctl(0, 1, 0, 0, 0, 1); tick();
    check_val("ba_rb_out", r_out_sel, 32'h4);
    ctl(1, 1, 0, 1, 0, 0); tick();
    check_val("prio_in_sel", r_in_sel, 32'h20);
    ctl(1, 0, 0, 1, 1, 0); tick();
    check_val("both_in_sel", r_in_sel, 32'h20);
    check_val("both_out_sel", r_out_sel, 32'h20);
    ctl(0, 0, 0, 0, 0, 0);
    ir_in = 32'h0; ir_load = 1'b1; tick();
    ir_load = 1'b0;
    ctl(1, 0, 0, 0, 0, 1); tick();
    check_val("ba_zero_out", r_out_sel, 32'd0);
    ctl(1, 0, 0, 0, 1, 0); tick();
    check_val("rout_zero_out", r_out_sel, 32'h1);

    // Load/decode collision: decode sees the pre-load IR
    ctl(0, 0, 0, 0, 0, 0);
    ir_in = 32'h02938000; ir_load = 1'b1; tick();
    ir_in = 32'h04800000;
    ctl(1, 0, 0, 1, 0, 0); tick();
    check_val("coll_old_ir", r_in_sel, 32'h20);
    ir_load = 1'b0; tick();
    check_val("coll_new_ir", r_in_sel, 32'h200);
    check_val("coll_sel_idx", 32'(sel_index), 32'd9);

    // Full scan with scan_ready tied high
    ctl(0, 0, 0, 0, 0, 0);
    scan_ready = 1'b1; scan_start = 1'b1; tick();
    scan_start = 1'b0;
    check_val("scan_out_0", r_out_sel, 32'h1);
    check_val("scan_valid_0", 32'(scan_valid), 32'd1);
    check_val("scan_busy_0", 32'(scan_busy), 32'd1);
    for (int k = 1; k < 16; k++) begin
      tick();
      check_val($sformatf("scan_out_%0d", k), r_out_sel, 32'd1 << k);
      check_val($sformatf("scan_idx_%0d", k), 32'(sel_index), 32'(k));
    end
    tick();
    check_val("scan_done_hi", 32'(scan_done), 32'd1);
    check_val("scan_done_out", r_out_sel, 32'd0);
    check_val("scan_done_valid", 32'(scan_valid), 32'd0);
    check_val("scan_done_busy", 32'(scan_busy), 32'd1);
    tick();
    check_val("scan_end_done", 32'(scan_done), 32'd0);
    check_val("scan_end_busy", 32'(scan_busy), 32'd0);
    check_val("scan_end_out", r_out_sel, 32'd0);
    check_val("scan_end_in", r_in_sel, 32'd0);

    // Backpressure at idx=4, with scan_start and decode inputs active meanwhile
    scan_start = 1'b1; tick();
    scan_start = 1'b0;
    for (int k = 1; k <= 4; k++) tick();
    check_val("bp_at4_out", r_out_sel, 32'h10);
    scan_ready = 1'b0; scan_start = 1'b1;
    ctl(1, 0, 0, 1, 0, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check_val($sformatf("bp_hold_out_%0d", k), r_out_sel, 32'h10);
      check_val($sformatf("bp_hold_idx_%0d", k), 32'(sel_index), 32'd4);
      check_val($sformatf("bp_hold_in_%0d", k), r_in_sel, 32'd0);
    end
    scan_start = 1'b0; scan_ready = 1'b1;
    ctl(0, 0, 0, 0, 0, 0);
    tick();
    check_val("bp_resume_out", r_out_sel, 32'h20);
    for (int k = 6; k < 16; k++) tick();
    check_val("bp_last_out", r_out_sel, 32'h8000);
    tick();
    check_val("bp_done_hi", 32'(scan_done), 32'd1);
    tick();
    check_val("bp_idle_busy", 32'(scan_busy), 32'd0);
    tick();
    check_val("bp_no_queue_busy", 32'(scan_busy), 32'd0);
    check_val("bp_no_queue_out", r_out_sel, 32'd0);

    // Reset mid-scan at idx=7
    scan_start = 1'b1; tick();
    scan_start = 1'b0;
    for (int k = 1; k <= 7; k++) tick();
    check_val("rmid_at7_out", r_out_sel, 32'h80);
    #2;
    clear = 1'b1;
    #1;
    check_val("rmid_out", r_out_sel, 32'd0);
    check_val("rmid_in", r_in_sel, 32'd0);
    check_val("rmid_idx", 32'(sel_index), 32'd0);
    check_val("rmid_busy", 32'(scan_busy), 32'd0);
    check_val("rmid_valid", 32'(scan_valid), 32'd0);
    check_val("rmid_done", 32'(scan_done), 32'd0);
    tick();
    @(negedge clock);
    clear = 1'b0;
    tick();
    check_val("rmid_post_done_a", 32'(scan_done), 32'd0);
    tick();
    check_val("rmid_post_done_b", 32'(scan_done), 32'd0);
    scan_ready = 1'b0;
    ctl(1, 0, 0, 1, 0, 0); tick();
    check_val("rmid_ir_cleared", r_in_sel, 32'h1);
    ctl(0, 0, 0, 0, 0, 0);
    scan_start = 1'b1; tick();
    scan_start = 1'b0;
    check_val("rmid_restart_out", r_out_sel, 32'h1);
    check_val("rmid_restart_valid", 32'(scan_valid), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
